// File: rtl/thermostat_ctrl.sv
// Thermostat controller: turns a valid-qualified temperature sample stream into
// mutually exclusive heater/AC enables. It applies hysteresis on mode exit, a
// minimum run time in HEAT/COOL, a dead time in IDLE before any mode entry, and
// a sensor-timeout FAULT state. All outputs are registered decodes of the
// next state, so they change on the same edge as the state itself.
module thermostat_ctrl #(
  parameter int WIDTH     = 8,
  parameter int LOW_TH    = 20,
  parameter int HIGH_TH   = 25,
  parameter int HYST      = 1,
  parameter int MIN_RUN   = 16,
  parameter int DEAD_TIME = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             temp_valid,
  input  logic [WIDTH-1:0] temperature,
  output logic             heater_on,
  output logic             ac_on,
  output logic [1:0]       state,
  output logic             fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HEAT  = 2'd1,
    ST_COOL  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Counter widths are just wide enough to hold their saturation value.
  localparam int DW = $clog2(DEAD_TIME + 1);
  localparam int RW = $clog2(MIN_RUN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] DEAD_MAX = DW'(DEAD_TIME);
  localparam logic [DW-1:0] DEAD_ONE = DW'(1);
  localparam logic [DW-1:0] DEAD_ZERO = DW'(0);
  localparam logic [RW-1:0] RUN_MAX  = RW'(MIN_RUN);
  localparam logic [RW-1:0] RUN_ONE  = RW'(1);
  localparam logic [RW-1:0] RUN_ZERO = RW'(0);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [TW-1:0] TO_ZERO  = TW'(0);

  // Entry thresholds and hysteresis-shifted exit thresholds, fixed at elaboration.
  localparam logic [WIDTH-1:0] HEAT_ENTER = WIDTH'(LOW_TH);
  localparam logic [WIDTH-1:0] COOL_ENTER = WIDTH'(HIGH_TH);
  localparam logic [WIDTH-1:0] HEAT_EXIT  = WIDTH'(LOW_TH + HYST);
  localparam logic [WIDTH-1:0] COOL_EXIT  = WIDTH'(HIGH_TH - HYST);

  state_e          state_q, state_d;
  logic [DW-1:0]   dead_q, dead_d;
  logic [RW-1:0]   run_q, run_d;
  logic [TW-1:0]   to_q, to_d;
  logic            heater_q, ac_q, fault_q;

  logic            timeout_s;
  logic            dead_done_s;
  logic            run_done_s;
  logic            want_heat_s;
  logic            want_cool_s;
  logic            heat_exit_s;
  logic            cool_exit_s;

  // Condition decode: the timeout fires on the edge where the silent-cycle count reaches TIMEOUT.
  always_comb begin
    timeout_s   = (~temp_valid) && (to_q >= TO_LAST);
    dead_done_s = (dead_q == DEAD_MAX);
    run_done_s  = (run_q == RUN_MAX);
    want_heat_s = (temperature < HEAT_ENTER);
    want_cool_s = (temperature > COOL_ENTER);
    heat_exit_s = (temperature >= HEAT_EXIT);
    cool_exit_s = (temperature <= COOL_EXIT);
  end

  // Next-state logic; priority is timeout, then FAULT recovery, then enable=0, then thresholds.
  always_comb begin
    state_d = state_q;
    if (timeout_s) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      // The recovering sample only brings us back to IDLE; it is not evaluated further.
      if (temp_valid) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_FAULT;
      end
    end else if (!enable) begin
      state_d = ST_IDLE;
    end else if (temp_valid) begin
      case (state_q)
        ST_IDLE: begin
          // Requests made before the dead time expires are dropped, not queued.
          if (dead_done_s && want_heat_s) begin
            state_d = ST_HEAT;
          end else if (dead_done_s && want_cool_s) begin
            state_d = ST_COOL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HEAT: begin
          if (run_done_s && heat_exit_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HEAT;
          end
        end
        ST_COOL: begin
          if (run_done_s && cool_exit_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COOL;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Counter next-state: any state change clears dead/run; temp_valid clears the timeout count.
  always_comb begin
    dead_d = DEAD_ZERO;
    run_d  = RUN_ZERO;
    to_d   = to_q;
    if (temp_valid) begin
      to_d = TO_ZERO;
    end else if (to_q == TO_MAX) begin
      to_d = to_q;
    end else begin
      to_d = to_q + TO_ONE;
    end

    if (state_d != state_q) begin
      dead_d = DEAD_ZERO;
      run_d  = RUN_ZERO;
    end else if (state_q == ST_IDLE) begin
      run_d = RUN_ZERO;
      if (dead_q == DEAD_MAX) begin
        dead_d = dead_q;
      end else begin
        dead_d = dead_q + DEAD_ONE;
      end
    end else if ((state_q == ST_HEAT) || (state_q == ST_COOL)) begin
      dead_d = DEAD_ZERO;
      if (run_q == RUN_MAX) begin
        run_d = run_q;
      end else begin
        run_d = run_q + RUN_ONE;
      end
    end else begin
      dead_d = DEAD_ZERO;
      run_d  = RUN_ZERO;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dead_q  <= DEAD_ZERO;
      run_q   <= RUN_ZERO;
      to_q    <= TO_ZERO;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
      run_q   <= run_d;
      to_q    <= to_d;
    end
  end

  // Registered output decode of the next state; heater and AC cannot both be set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heater_q <= 1'b0;
      ac_q     <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      heater_q <= (state_d == ST_HEAT);
      ac_q     <= (state_d == ST_COOL);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign heater_on = heater_q;
  assign ac_on     = ac_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed bench for thermostat_ctrl with default parameters
// (LOW_TH=20, HIGH_TH=25, HYST=1, MIN_RUN=16, DEAD_TIME=4, TIMEOUT=64).
module tb_thermostat_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       temp_valid;
  logic [7:0] temperature;
  logic       heater_on;
  logic       ac_on;
  logic [1:0] state;
  logic       fault;

  int errors;
  int checks;

  thermostat_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .temp_valid  (temp_valid),
    .temperature (temperature),
    .heater_on   (heater_on),
    .ac_on       (ac_on),
    .state       (state),
    .fault       (fault)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full output check: state, heater, ac, fault.
  task automatic chk_all(input string tag, input logic [1:0] st, input logic h,
                         input logic a, input logic f);
    chk({tag, ".state"}, {6'd0, state}, {6'd0, st});
    chk({tag, ".heater"}, {7'd0, heater_on}, {7'd0, h});
    chk({tag, ".ac"}, {7'd0, ac_on}, {7'd0, a});
    chk({tag, ".fault"}, {7'd0, fault}, {7'd0, f});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic en, input logic v, input logic [7:0] t);
    enable      = en;
    temp_valid  = v;
    temperature = t;
    @(posedge clk);
    #1;
  endtask

  // Heater and AC must never be on together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!((heater_on === 1'b1) && (ac_on === 1'b1))) else begin
        errors++;
        $error("FAIL excl: observed heater=%0b ac=%0b expected not both 1", heater_on, ac_on);
      end
    end
  end

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    enable      = 1'b1;
    temp_valid  = 1'b0;
    temperature = 8'd0;

    // Reset state
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Dead time after reset: dead_cnt 0,1,2 with neutral samples.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd22);
    // Heat request at dead_cnt=3 is dropped.
    step(1'b1, 1'b1, 8'd15);
    chk_all("heat_early", 2'd0, 1'b0, 1'b0, 1'b0);
    // At dead_cnt=4 the request is taken.
    step(1'b1, 1'b1, 8'd15);
    chk_all("heat_enter", 2'd1, 1'b1, 1'b0, 1'b0);

    // Run cycles 0..14, then 21 at run_cnt=15 must not exit (min run).
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 8'd18);
    step(1'b1, 1'b1, 8'd21);
    chk_all("heat_minrun", 2'd1, 1'b1, 1'b0, 1'b0);
    // run_cnt=16: 20 is inside the hysteresis band, stays HEAT.
    step(1'b1, 1'b1, 8'd20);
    chk_all("heat_hyst", 2'd1, 1'b1, 1'b0, 1'b0);
    // 21 = LOW_TH+HYST exits.
    step(1'b1, 1'b1, 8'd21);
    chk_all("heat_exit", 2'd0, 1'b0, 1'b0, 1'b0);

    // No direct swap: cool request one cycle into IDLE is dropped.
    step(1'b1, 1'b1, 8'd30);
    chk_all("swap_block", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd22);
    step(1'b1, 1'b1, 8'd30);
    chk_all("cool_enter", 2'd2, 1'b0, 1'b1, 1'b0);

    // Min run in COOL: 22 on run cycle 5 (run_cnt=4) stays.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd28);
    step(1'b1, 1'b1, 8'd22);
    chk_all("cool_minrun", 2'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 8'd28);
    // run_cnt=16: 25 is above HIGH_TH-HYST=24, stays.
    step(1'b1, 1'b1, 8'd25);
    chk_all("cool_hyst", 2'd2, 1'b0, 1'b1, 1'b0);
    // 24 exits.
    step(1'b1, 1'b1, 8'd24);
    chk_all("cool_exit", 2'd0, 1'b0, 1'b0, 1'b0);

    // Back into COOL for the timeout test.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd22);
    step(1'b1, 1'b1, 8'd30);
    chk_all("cool_reenter", 2'd2, 1'b0, 1'b1, 1'b0);
    // 63 silent cycles: still COOL.
    for (int i = 0; i < 63; i++) step(1'b1, 1'b0, 8'd0);
    chk_all("to_63", 2'd2, 1'b0, 1'b1, 1'b0);
    // 64th silent cycle: FAULT.
    step(1'b1, 1'b0, 8'd0);
    chk_all("to_fault", 2'd3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'd0);
    chk_all("fault_hold", 2'd3, 1'b0, 1'b0, 1'b1);
    // First valid sample recovers to IDLE only, even though it asks for cooling.
    step(1'b1, 1'b1, 8'd30);
    chk_all("fault_exit", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd30);
    chk_all("fault_dead", 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd30);
    chk_all("fault_cool", 2'd2, 1'b0, 1'b1, 1'b0);

    // Enable low overrides min run from COOL.
    step(1'b0, 1'b1, 8'd30);
    chk_all("dis_cool", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd22);
    step(1'b1, 1'b1, 8'd15);
    chk_all("heat_again", 2'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'd15);
    // run_cnt=3, enable=0 -> IDLE.
    step(1'b0, 1'b1, 8'd10);
    chk_all("dis_heat", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'd10);
    chk_all("dis_hold", 2'd0, 1'b0, 1'b0, 1'b0);
    // Dead time elapsed while disabled, so re-enable takes heating at once.
    step(1'b1, 1'b1, 8'd10);
    chk_all("reenable", 2'd1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-HEAT, observed before any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd15);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'd15);
    chk_all("rst_dead", 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'd15);
    chk_all("rst_heat", 2'd1, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/thermostat_ctrl.md
Name: thermostat_ctrl

Overview:
- Clocked, parametrised thermostat controller. It supersedes the purely combinational threshold compare.
- Consumes a valid-qualified temperature sample stream and drives mutually exclusive heater and AC enables.
- Adds hysteresis, minimum run time, dead time between modes, and a sensor-timeout fault.
- Sits between the temperature sensor interface and the actuator drivers.

Parameters:
- WIDTH, 8: temperature sample width, unsigned, integer degrees C.
- LOW_TH, 20: sample < LOW_TH requests heating.
- HIGH_TH, 25: sample > HIGH_TH requests cooling. Constraint: LOW_TH + HYST <= HIGH_TH - HYST.
- HYST, 1: hysteresis band applied on exit from HEAT and COOL.
- MIN_RUN, 16: minimum cycles in HEAT or COOL before a threshold-driven exit. Must be >= 1.
- DEAD_TIME, 4: minimum cycles in IDLE before entering HEAT or COOL. Must be >= 1.
- TIMEOUT, 64: cycles without temp_valid before entering FAULT. Must be >= 2.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: controller enable. When low, forces IDLE.
- temp_valid, input, 1: temperature is valid this cycle.
- temperature, input, WIDTH: temperature sample, unsigned.
- heater_on, output, 1: heater enable, registered.
- ac_on, output, 1: AC enable, registered.
- state, output, 2: current state. IDLE=0, HEAT=1, COOL=2, FAULT=3.
- fault, output, 1: high while in FAULT, registered.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE; heater_on, ac_on and fault = 0; run, dead and timeout counters = 0.
- Outputs are a registered decode of the state: heater_on = (state==HEAT), ac_on = (state==COOL), fault = (state==FAULT). heater_on and ac_on are never high together.
- Latency: a sample with temp_valid high at edge k updates state and outputs at edge k. The new values are visible in cycle k+1. No other pipeline stages.
- Samples are evaluated only when temp_valid=1. Between valid samples, state holds except for the counter-driven transitions listed below.
- Counters:
  - dead_cnt counts cycles in IDLE and saturates at DEAD_TIME.
  - run_cnt counts cycles in HEAT or COOL and saturates at MIN_RUN.
  - to_cnt counts cycles since the last temp_valid and saturates at TIMEOUT.
  - On any state change, dead_cnt and run_cnt clear.
  - temp_valid clears to_cnt.
  - Counter widths are $clog2(limit+1).
- IDLE:
  - Valid sample < LOW_TH and dead_cnt == DEAD_TIME -> HEAT.
  - Valid sample > HIGH_TH and dead_cnt == DEAD_TIME -> COOL.
  - Samples in between, or dead_cnt not yet expired -> stay in IDLE. A request arriving before dead_cnt expires is dropped, not queued; the next valid sample re-evaluates.
- HEAT: valid sample >= LOW_TH + HYST and run_cnt == MIN_RUN -> IDLE. Otherwise stay.
- COOL: valid sample <= HIGH_TH - HYST and run_cnt == MIN_RUN -> IDLE. Otherwise stay.
- There is no direct HEAT<->COOL transition. Every mode change passes through IDLE for at least DEAD_TIME cycles.
- Timeout: to_cnt reaching TIMEOUT with temp_valid low in that cycle -> FAULT from any state. Outputs go off next cycle, ignoring MIN_RUN.
- FAULT: the first valid sample -> IDLE with dead_cnt = 0. That sample is not otherwise evaluated.
- enable=0: next edge -> IDLE from any state except FAULT. This overrides MIN_RUN. to_cnt keeps running, so FAULT can still be entered.
- Priority in the same cycle, highest first: reset > timeout > enable=0 > threshold transition.
- Comparisons are unsigned and WIDTH-bit. LOW_TH+HYST and HIGH_TH-HYST are computed at elaboration.

Test Plan:
- Reset mid-HEAT: assert rst_n=0 asynchronously -> heater_on=0, state=0 with no clock edge. After release, the controller re-enters HEAT only after 4 IDLE cycles plus a sample of 15.
- Heat with hysteresis: after dead time, sample 15 -> state=1, heater_on=1 next cycle. Sample 20 at run_cnt=16 -> stays HEAT. Sample 21 -> IDLE.
- Min run: enter COOL with sample 30. Sample 22 on run cycle 5 -> stays COOL. Sample 22 at run_cnt=16 -> IDLE, ac_on=0.
- Dead time, no direct mode swap: in HEAT, sample 21 -> IDLE. Sample 30 one cycle later -> stays IDLE. Sample 30 after 4 IDLE cycles -> COOL. At no cycle are heater_on and ac_on both 1.
- Sensor timeout: in COOL, hold temp_valid=0 for 64 cycles -> state=3, fault=1, ac_on=0. First valid sample 30 -> IDLE. After 4 cycles, a further sample 30 -> COOL.
- Enable override: in HEAT at run_cnt=3, enable=0 -> IDLE next edge. Samples of 10 while disabled -> stays IDLE, heater_on=0.
